// File: rtl/sv32_pkg.sv
// Sv32 page-table walker shared definitions: PTE bit positions, access codes,
// walker states and PTE/PA address helpers.
package sv32_pkg;

   localparam int PTE_V = 0;
   localparam int PTE_R = 1;
   localparam int PTE_W = 2;
   localparam int PTE_X = 3;
   localparam int PTE_U = 4;
   localparam int PTE_G = 5;
   localparam int PTE_A = 6;
   localparam int PTE_D = 7;

   localparam logic [1:0] ACC_FETCH = 2'b00;
   localparam logic [1:0] ACC_LOAD  = 2'b01;
   localparam logic [1:0] ACC_STORE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_L1_REQ,
      ST_L1_WAIT,
      ST_L0_REQ,
      ST_L0_WAIT,
      ST_DONE
   } ptw_state_e;

   function automatic logic [33:0] l1_pte_addr(input logic [21:0] root_ppn, input logic [9:0] vpn1);
      return {root_ppn, 12'h000} + {22'd0, vpn1, 2'b00};
   endfunction

   function automatic logic [33:0] l0_pte_addr(input logic [21:0] pte_ppn, input logic [9:0] vpn0);
      return {pte_ppn, 12'h000} + {22'd0, vpn0, 2'b00};
   endfunction

   // True when any bit at or above paddr_w is set in a 34-bit physical address.
   function automatic logic pa_out_of_range(input logic [33:0] pa, input int unsigned paddr_w);
      return (paddr_w >= 34) ? 1'b0 : (|(pa >> paddr_w));
   endfunction

endpackage

// File: rtl/sv32_pte_check.sv
// Combinational Sv32 PTE decode: classifies a fetched PTE as leaf / pointer
// and applies validity, alignment, privilege and A/D rules.
module sv32_pte_check
   import sv32_pkg::*;
(
   input  logic [31:0] i_pte,
   input  logic        i_level,       // 1 = L1 (superpage level), 0 = L0
   input  logic [1:0]  i_acc,
   input  logic        i_priv_u,
   input  logic        i_sum,
   input  logic        i_mxr,
   output logic        o_leaf,
   output logic        o_next_level,
   output logic        o_page_fault
);

   logic w_v, w_r, w_w, w_x, w_u, w_a, w_d;
   logic w_malformed, w_is_leaf, w_misaligned;
   logic w_perm_fault, w_priv_fault, w_ad_fault;
   logic w_unused;

   assign w_v = i_pte[PTE_V];
   assign w_r = i_pte[PTE_R];
   assign w_w = i_pte[PTE_W];
   assign w_x = i_pte[PTE_X];
   assign w_u = i_pte[PTE_U];
   assign w_a = i_pte[PTE_A];
   assign w_d = i_pte[PTE_D];
   assign w_unused = ^{i_pte[31:20], i_pte[9:8], i_pte[PTE_G]};

   assign w_malformed  = ~w_v | (~w_r & w_w);
   assign w_is_leaf    = w_r | w_x;
   assign w_misaligned = i_level & (|i_pte[19:10]);

   always_comb begin
      w_perm_fault = 1'b0;
      case (i_acc)
         ACC_FETCH: w_perm_fault = ~w_x;
         ACC_STORE: w_perm_fault = ~w_w;
         default:   w_perm_fault = ~(w_r | (i_mxr & w_x));
      endcase
   end

   // S-mode never executes from U pages; data access to U pages only with SUM.
   assign w_priv_fault = i_priv_u ? ~w_u : (w_u & ((i_acc == ACC_FETCH) | ~i_sum));
   assign w_ad_fault   = ~w_a | ((i_acc == ACC_STORE) & ~w_d);

   assign o_leaf       = ~w_malformed & w_is_leaf;
   assign o_next_level = ~w_malformed & ~w_is_leaf & i_level;
   assign o_page_fault = w_malformed |
                         (w_is_leaf ? (w_misaligned | w_perm_fault | w_priv_fault | w_ad_fault)
                                    : ~i_level);

endmodule

// File: rtl/mmu_sv32_ptw.sv
// Sv32 two-level hardware page-table walker with bare-mode passthrough.
// One walk in flight; result is a single-cycle pulse with no back-pressure.
module mmu_sv32_ptw
   import sv32_pkg::*;
#(
   parameter int PADDR_W = 32     // 12..32: memory-visible physical address width
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_satp_mode,
   input  logic [21:0] i_satp_ppn,
   input  logic        i_priv_u,
   input  logic        i_sum,
   input  logic        i_mxr,
   input  logic        i_flush,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_vaddr,
   input  logic [1:0]  i_req_acc,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_paddr,
   output logic        o_resp_page_fault,
   output logic        o_resp_access_fault,
   output logic        o_mem_trans_rden,
   output logic [31:0] o_mem_trans_riaddr,
   input  logic [31:0] i_mem_trans_roaddr,
   input  logic        i_mem_trans_rvalid,
   input  logic [31:0] i_mem_trans_rdata,
   input  logic        i_mem_wait
);

   ptw_state_e  r_state, w_nxt_state;

   logic [21:0] r_vaddr;          // VPN[0] and page offset; VPN[1] only matters at accept
   logic [1:0]  r_acc;
   logic        r_priv_u, r_sum, r_mxr;
   logic [31:0] r_addr;
   logic [31:0] r_paddr;
   logic        r_pf, r_af;

   logic        w_accept, w_ld_addr, w_fin, w_fin_pf, w_fin_af;
   logic [31:0] w_nxt_addr, w_fin_pa;
   logic [33:0] w_pa34;
   logic [33:0] w_l1_addr, w_l0_addr;
   logic        w_beat, w_level;
   logic        w_pte_leaf, w_pte_next, w_pte_pf;

   assign o_req_ready = (r_state == ST_IDLE) & ~i_flush;
   assign w_l1_addr   = l1_pte_addr(i_satp_ppn, i_req_vaddr[31:22]);
   assign w_l0_addr   = l0_pte_addr(i_mem_trans_rdata[31:10], r_vaddr[21:12]);
   assign w_level     = (r_state == ST_L1_WAIT);
   // Beats tagged with another address belong to someone else and are dropped.
   assign w_beat      = i_mem_trans_rvalid & (i_mem_trans_roaddr == r_addr);

   sv32_pte_check u_pte_check (
      .i_pte        (i_mem_trans_rdata),
      .i_level      (w_level),
      .i_acc        (r_acc),
      .i_priv_u     (r_priv_u),
      .i_sum        (r_sum),
      .i_mxr        (r_mxr),
      .o_leaf       (w_pte_leaf),
      .o_next_level (w_pte_next),
      .o_page_fault (w_pte_pf)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_nxt_state;
   end

   always_comb begin
      w_nxt_state = r_state;
      w_accept    = 1'b0;
      w_ld_addr   = 1'b0;
      w_nxt_addr  = r_addr;
      w_fin       = 1'b0;
      w_fin_pf    = 1'b0;
      w_fin_af    = 1'b0;
      w_fin_pa    = '0;
      w_pa34      = '0;
      case (r_state)
         ST_IDLE: begin
            if (i_req_valid && o_req_ready) begin
               w_accept = 1'b1;
               if (!i_satp_mode) begin
                  w_fin    = 1'b1;
                  w_fin_af = pa_out_of_range({2'b00, i_req_vaddr}, PADDR_W);
                  w_fin_pa = w_fin_af ? '0 : i_req_vaddr;
               end else if (pa_out_of_range(w_l1_addr, PADDR_W)) begin
                  w_fin    = 1'b1;
                  w_fin_af = 1'b1;
               end else begin
                  w_ld_addr   = 1'b1;
                  w_nxt_addr  = w_l1_addr[31:0];
                  w_nxt_state = ST_L1_REQ;
               end
            end
         end
         ST_L1_REQ: if (!i_mem_wait) w_nxt_state = ST_L1_WAIT;
         ST_L0_REQ: if (!i_mem_wait) w_nxt_state = ST_L0_WAIT;
         ST_L1_WAIT, ST_L0_WAIT: begin
            if (w_beat) begin
               if (w_pte_pf) begin
                  w_fin    = 1'b1;
                  w_fin_pf = 1'b1;
               end else if (w_pte_next) begin
                  if (pa_out_of_range(w_l0_addr, PADDR_W)) begin
                     w_fin    = 1'b1;
                     w_fin_af = 1'b1;
                  end else begin
                     w_ld_addr   = 1'b1;
                     w_nxt_addr  = w_l0_addr[31:0];
                     w_nxt_state = ST_L0_REQ;
                  end
               end else if (w_pte_leaf) begin
                  w_pa34   = w_level ? {i_mem_trans_rdata[31:20], r_vaddr}
                                     : {i_mem_trans_rdata[31:10], r_vaddr[11:0]};
                  w_fin    = 1'b1;
                  w_fin_af = pa_out_of_range(w_pa34, PADDR_W);
                  w_fin_pa = w_fin_af ? '0 : w_pa34[31:0];
               end else begin
                  w_fin    = 1'b1;
                  w_fin_pf = 1'b1;
               end
            end
         end
         ST_DONE: w_nxt_state = ST_IDLE;
         default: w_nxt_state = ST_IDLE;
      endcase
      if (w_fin) w_nxt_state = ST_DONE;
      // Flush wins over everything, including a result that is about to land.
      if (i_flush) begin
         w_nxt_state = ST_IDLE;
         w_fin       = 1'b0;
         w_ld_addr   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vaddr  <= '0;
         r_acc    <= '0;
         r_priv_u <= 1'b0;
         r_sum    <= 1'b0;
         r_mxr    <= 1'b0;
         r_addr   <= '0;
         r_paddr  <= '0;
         r_pf     <= 1'b0;
         r_af     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_vaddr  <= i_req_vaddr[21:0];
            r_acc    <= i_req_acc;
            r_priv_u <= i_priv_u;
            r_sum    <= i_sum;
            r_mxr    <= i_mxr;
         end
         if (w_ld_addr) r_addr <= w_nxt_addr;
         if (w_fin) begin
            r_paddr <= w_fin_pa;
            r_pf    <= w_fin_pf;
            r_af    <= w_fin_pf ? 1'b0 : w_fin_af;
         end
      end
   end

   assign o_resp_valid        = (r_state == ST_DONE) & ~i_flush;
   assign o_resp_paddr        = o_resp_valid ? r_paddr : '0;
   assign o_resp_page_fault   = o_resp_valid & r_pf;
   assign o_resp_access_fault = o_resp_valid & r_af;
   assign o_mem_trans_rden    = ((r_state == ST_L1_REQ) | (r_state == ST_L0_REQ)) & ~i_flush;
   assign o_mem_trans_riaddr  = r_addr;

endmodule
